soc_eeg_streamer: RTL and testbench

// - SoC-side initiator for the CiM SoC interface: buffers incoming ADC EEG samples, and per sleep epoch drives
//   new_sleep_epoch, start_eeg_load and a paced new_eeg_data/eeg stream into the CiM, then captures the inferred stage.
// - Sits between the ADC front-end and cim_centralized; replaces bench-driven stimulus on the SoC interface in silicon.

---
 rtl/soc_eeg_streamer_pkg.sv | 17 +
 rtl/soc_eeg_streamer_sample_fifo.sv | 52 +++++
 rtl/soc_eeg_streamer.sv | 126 ++++++++++++
 tb/tb_soc_eeg_streamer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_eeg_streamer_pkg.sv
// soc_eeg_streamer_pkg: shared data types, FSM encoding and parameter defaults
// for the SoC-side EEG streamer.
package soc_eeg_streamer_pkg;
    typedef logic [15:0] AdcData_t;
    typedef logic [2:0]  SleepStage_t;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EPOCH    = 3'd1,
        ST_START    = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WAIT_INF = 3'd4
    } SocStreamState_t;
    localparam int DEF_NUM_SAMPLES = 3840;
    localparam int DEF_SAMPLE_GAP  = 4;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int DEF_INF_TIMEOUT = 2**20;
endpackage

// File: rtl/soc_eeg_streamer_sample_fifo.sv
// soc_eeg_streamer_sample_fifo: synchronous ADC sample FIFO with flush.
// A push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
module soc_eeg_streamer_sample_fifo
    import soc_eeg_streamer_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  logic     i_pop,
    input  logic     i_flush,
    input  AdcData_t i_data,
    output AdcData_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int AW = $clog2(DEPTH);

    AdcData_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_wr ? r_wr + 1'b1 : r_wr;
            r_rd  <= w_rd ? r_rd + 1'b1 : r_rd;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/soc_eeg_streamer.sv
// soc_eeg_streamer: buffers ADC samples and, once per epoch, announces the epoch to the CiM,
// streams NUM_SAMPLES paced samples into it and captures the inferred sleep stage.
module soc_eeg_streamer
    import soc_eeg_streamer_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int SAMPLE_GAP  = DEF_SAMPLE_GAP,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int INF_TIMEOUT = DEF_INF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_epoch_tick,
    input  logic        i_adc_valid,
    input  AdcData_t    i_adc_data,
    input  logic        i_clear_flags,
    output logic        o_cim_new_sleep_epoch,
    output logic        o_cim_start_eeg_load,
    output logic        o_cim_new_eeg_data,
    output AdcData_t    o_cim_eeg,
    input  logic        i_cim_inference_complete,
    input  SleepStage_t i_cim_inferred_sleep_stage,
    output logic        o_stage_valid,
    output SleepStage_t o_sleep_stage,
    output logic        o_busy,
    output logic        o_overflow,
    output logic        o_epoch_missed,
    output logic        o_timeout_err
);
    localparam int GW = $clog2(SAMPLE_GAP + 1);
    localparam int TW = $clog2(INF_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP      = GW'(SAMPLE_GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(INF_TIMEOUT - 1);
    localparam logic [11:0]   CNT_LAST = 12'(NUM_SAMPLES - 1);

    SocStreamState_t r_state;
    SocStreamState_t w_next;
    logic [11:0]     r_cnt;
    logic [GW-1:0]   r_gap;
    logic [TW-1:0]   r_tmo;
    logic            r_eeg_pulse;
    logic            r_stage_valid;
    logic            r_overflow;
    logic            r_epoch_missed;
    logic            r_timeout_err;
    AdcData_t        r_eeg;
    SleepStage_t     r_stage;
    AdcData_t        w_fifo_data;
    logic            w_start;
    logic            w_push;
    logic            w_pop;
    logic            w_last;
    logic            w_done;
    logic            w_tmo;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;

    assign w_start = i_epoch_tick && r_state == ST_IDLE;
    assign w_push  = i_adc_valid && (r_state inside {ST_EPOCH, ST_START, ST_STREAM});
    assign w_pop   = r_state == ST_STREAM && !w_empty && r_gap >= GAP;
    assign w_last  = w_pop && r_cnt == CNT_LAST;
    assign w_done  = r_state == ST_WAIT_INF && i_cim_inference_complete;
    assign w_tmo   = r_state == ST_WAIT_INF && !i_cim_inference_complete && r_tmo == TMO_LAST;
    assign w_drop  = w_push && w_full && !w_pop;

    always_comb begin
        w_next = w_start                ? ST_EPOCH    :
                 r_state == ST_EPOCH    ? ST_START    :
                 r_state == ST_START    ? ST_STREAM   :
                 w_last                 ? ST_WAIT_INF :
                 (w_done || w_tmo)      ? ST_IDLE     : r_state;
    end

    soc_eeg_streamer_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_sample_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_start),
        .i_data  (i_adc_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Gap counter starts saturated so the first sample may go out right after START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_gap          <= '0;
            r_tmo          <= '0;
            r_eeg_pulse    <= 1'b0;
            r_eeg          <= '0;
            r_stage_valid  <= 1'b0;
            r_stage        <= '0;
            r_overflow     <= 1'b0;
            r_epoch_missed <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_start ? '0 : r_cnt + 12'(w_pop);
            r_gap          <= r_state == ST_START ? GAP : w_pop ? GW'(1) : r_gap < GAP ? r_gap + 1'b1 : r_gap;
            r_tmo          <= r_state == ST_WAIT_INF ? r_tmo + 1'b1 : '0;
            r_eeg_pulse    <= w_pop;
            r_eeg          <= w_pop ? w_fifo_data : r_eeg;
            r_stage_valid  <= w_done;
            r_stage        <= w_done ? i_cim_inferred_sleep_stage : r_stage;
            r_overflow     <= w_drop || (r_overflow && !i_clear_flags);
            r_epoch_missed <= (i_epoch_tick && r_state != ST_IDLE) || (r_epoch_missed && !i_clear_flags);
            r_timeout_err  <= w_tmo || (r_timeout_err && !i_clear_flags);
        end
    end

    assign o_cim_new_sleep_epoch = r_state == ST_EPOCH;
    assign o_cim_start_eeg_load  = r_state == ST_START;
    assign o_cim_new_eeg_data    = r_eeg_pulse;
    assign o_cim_eeg             = r_eeg;
    assign o_stage_valid         = r_stage_valid;
    assign o_sleep_stage         = r_stage;
    assign o_busy                = r_state != ST_IDLE;
    assign o_overflow            = r_overflow;
    assign o_epoch_missed        = r_epoch_missed;
    assign o_timeout_err         = r_timeout_err;
endmodule

// File: tb/tb_soc_eeg_streamer.sv
// tb_soc_eeg_streamer: directed bench for soc_eeg_streamer with a behavioural epoch model
// checked every cycle, plus literal expectations per scenario.
module tb_soc_eeg_streamer;
    import soc_eeg_streamer_pkg::*;

    localparam int N     = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic        tick  = 1'b0;
    logic        valid = 1'b0;
    logic        clr   = 1'b0;
    logic        cmpl  = 1'b0;
    AdcData_t    adc   = '0;
    SleepStage_t stg_in = '0;

    logic a_ep, a_st, a_nd, a_sv, a_busy, a_ovf, a_miss, a_tmo;
    logic b_ep, b_st, b_nd, b_sv, b_busy, b_ovf, b_miss, b_tmo;
    logic ep, st, nd, sv, busy, ovf, miss, tmo_e;
    AdcData_t    a_eeg, b_eeg, eeg;
    SleepStage_t a_stage, b_stage, stage;

    always #5 clk = ~clk;

    soc_eeg_streamer #(.NUM_SAMPLES(N), .SAMPLE_GAP(GAP_A), .FIFO_DEPTH(DEPTH), .INF_TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_epoch_tick(tick && !sel), .i_adc_valid(valid && !sel), .i_adc_data(adc),
        .i_clear_flags(clr && !sel),
        .o_cim_new_sleep_epoch(a_ep), .o_cim_start_eeg_load(a_st), .o_cim_new_eeg_data(a_nd), .o_cim_eeg(a_eeg),
        .i_cim_inference_complete(cmpl && !sel), .i_cim_inferred_sleep_stage(stg_in),
        .o_stage_valid(a_sv), .o_sleep_stage(a_stage), .o_busy(a_busy),
        .o_overflow(a_ovf), .o_epoch_missed(a_miss), .o_timeout_err(a_tmo)
    );

    soc_eeg_streamer #(.NUM_SAMPLES(N), .SAMPLE_GAP(GAP_B), .FIFO_DEPTH(DEPTH), .INF_TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_epoch_tick(tick && sel), .i_adc_valid(valid && sel), .i_adc_data(adc),
        .i_clear_flags(clr && sel),
        .o_cim_new_sleep_epoch(b_ep), .o_cim_start_eeg_load(b_st), .o_cim_new_eeg_data(b_nd), .o_cim_eeg(b_eeg),
        .i_cim_inference_complete(cmpl && sel), .i_cim_inferred_sleep_stage(stg_in),
        .o_stage_valid(b_sv), .o_sleep_stage(b_stage), .o_busy(b_busy),
        .o_overflow(b_ovf), .o_epoch_missed(b_miss), .o_timeout_err(b_tmo)
    );

    assign ep    = sel ? b_ep    : a_ep;
    assign st    = sel ? b_st    : a_st;
    assign nd    = sel ? b_nd    : a_nd;
    assign eeg   = sel ? b_eeg   : a_eeg;
    assign sv    = sel ? b_sv    : a_sv;
    assign stage = sel ? b_stage : a_stage;
    assign busy  = sel ? b_busy  : a_busy;
    assign ovf   = sel ? b_ovf   : a_ovf;
    assign miss  = sel ? b_miss  : a_miss;
    assign tmo_e = sel ? b_tmo   : a_tmo;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 epoch announce, 2 load start, 3 streaming, 4 awaiting result.
    int          m_phase = 0, m_sent = 0, m_last_pop = -1000, m_wait_start = 0, m_cyc = 0;
    AdcData_t    m_q[$];
    logic        m_pop, m_drop, m_done, m_tout;
    AdcData_t    m_v;
    logic        e_ep = 0, e_st = 0, e_nd = 0, e_sv = 0, e_ovf = 0, e_miss = 0, e_tmo = 0;
    AdcData_t    e_eeg = '0;
    SleepStage_t e_stage = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_sent = 0; m_last_pop = -1000; m_q.delete();
            e_ep = 0; e_st = 0; e_nd = 0; e_sv = 0; e_ovf = 0; e_miss = 0; e_tmo = 0;
            e_eeg = '0; e_stage = '0;
        end else begin
            m_pop = m_phase == 3 && m_q.size() > 0 && (m_cyc - m_last_pop) >= (sel ? GAP_B : GAP_A);
            if (m_pop) begin
                m_v = m_q.pop_front();
                m_last_pop = m_cyc;
                m_sent++;
            end
            m_drop = 0;
            if (valid && m_phase inside {1, 2, 3}) begin
                if (m_q.size() < DEPTH) m_q.push_back(adc);
                else m_drop = 1;
            end
            m_done = m_phase == 4 && cmpl;
            m_tout = m_phase == 4 && !cmpl && (m_cyc - m_wait_start) == TMO - 1;
            e_ep   = m_phase == 0 && tick;
            e_st   = m_phase == 1;
            e_nd   = m_pop;
            if (m_pop) e_eeg = m_v;
            e_sv   = m_done;
            if (m_done) e_stage = stg_in;
            e_ovf  = m_drop || (e_ovf && !clr);
            e_miss = (tick && m_phase != 0) || (e_miss && !clr);
            e_tmo  = m_tout || (e_tmo && !clr);
            if (m_phase == 0 && tick) begin
                m_phase = 1; m_q.delete(); m_sent = 0; m_last_pop = -1000;
            end else if (m_phase == 1) m_phase = 2;
            else if (m_phase == 2) m_phase = 3;
            else if (m_phase == 3 && m_sent == N) begin
                m_phase = 4; m_wait_start = m_cyc + 1;
            end else if (m_phase == 4 && (m_done || m_tout)) m_phase = 0;
            m_cyc++;
        end
    end

    AdcData_t seen[$];
    int sv_cnt = 0, ep_cnt = 0;

    initial forever begin
        @(negedge clk);
        chk("new_sleep_epoch", ep,    e_ep);
        chk("start_eeg_load",  st,    e_st);
        chk("new_eeg_data",    nd,    e_nd);
        chk("eeg",             eeg,   e_eeg);
        chk("stage_valid",     sv,    e_sv);
        chk("sleep_stage",     stage, e_stage);
        chk("busy",            busy,  m_phase != 0);
        chk("overflow",        ovf,   e_ovf);
        chk("epoch_missed",    miss,  e_miss);
        chk("timeout_err",     tmo_e, e_tmo);
        if (nd) seen.push_back(eeg);
        if (sv) sv_cnt++;
        if (ep) ep_cnt++;
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1; @(negedge clk); tick = 0;
    endtask

    task automatic send(input AdcData_t d);
        adc = d; valid = 1; @(negedge clk); valid = 0;
    endtask

    task automatic complete(input SleepStage_t s);
        stg_in = s; cmpl = 1; @(negedge clk); cmpl = 0;
    endtask

    task automatic clear_flags();
        clr = 1; @(negedge clk); clr = 0;
    endtask

    task automatic new_test();
        seen.delete(); sv_cnt = 0; ep_cnt = 0;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k = 0;
        while (seen.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(name, seen.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin @(negedge clk); k++; end
        chk(name, busy, 0);
    endtask

    task automatic chk_seen(input string name, input AdcData_t e0, input AdcData_t e1,
                            input AdcData_t e2, input AdcData_t e3);
        AdcData_t exp [4];
        exp = '{e0, e1, e2, e3};
        chk({name, "_count"}, seen.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(name, i < seen.size() ? seen[i] : 16'hdead, exp[i]);
    endtask

    task automatic reset_pulse(input logic new_sel);
        @(negedge clk); #2 rst_n = 0; sel = new_sel;
        #1 chk("reset_outputs_zero", {ep, st, nd, eeg, sv, stage, busy, ovf, miss, tmo_e}, 0);
        cyc_n(2);
        @(negedge clk); #2 rst_n = 1;
    endtask

    initial begin
        cyc_n(3);
        chk("reset_busy", busy, 0);
        chk("reset_stage", stage, 0);
        @(negedge clk); #2 rst_n = 1;

        new_test();
        pulse_tick();
        send(16'h0011); send(16'h0022); send(16'h0033); send(16'h0044);
        wait_pulses(4, 40, "nominal_stream_done");
        complete(3'd3);
        cyc_n(3);
        chk_seen("nominal_eeg", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        chk("nominal_stage", stage, 3);
        chk("nominal_stage_valid_cnt", sv_cnt, 1);
        chk("nominal_epoch_cnt", ep_cnt, 1);

        new_test();
        complete(3'd5);
        cyc_n(3);
        chk("stray_complete_no_valid", sv_cnt, 0);
        chk("stray_complete_stage", stage, 3);

        new_test();
        pulse_tick();
        for (int i = 0; i < 4; i++) begin
            send(AdcData_t'(16'h0101 + i));
            cyc_n(9);
        end
        wait_pulses(4, 20, "starve_stream_done");
        complete(3'd1);
        cyc_n(3);
        chk_seen("starve_eeg", 16'h0101, 16'h0102, 16'h0103, 16'h0104);
        chk("starve_overflow", ovf, 0);
        chk("starve_stage", stage, 1);

        new_test();
        pulse_tick();
        send(16'h0201); send(16'h0202); send(16'h0203);
        tick = 1; clr = 1; @(negedge clk); tick = 0; clr = 0;
        send(16'h0204);
        wait_pulses(4, 40, "missed_stream_done");
        chk("missed_flag", miss, 1);
        chk("missed_epoch_cnt", ep_cnt, 1);
        complete(3'd2);
        cyc_n(2);
        clear_flags();
        chk("missed_cleared", miss, 0);

        new_test();
        pulse_tick();
        send(16'h0301); send(16'h0302); send(16'h0303); send(16'h0304);
        wait_pulses(4, 40, "timeout_stream_done");
        wait_idle(40, "timeout_back_idle");
        chk("timeout_flag", tmo_e, 1);
        chk("timeout_stage_held", stage, 2);
        chk("timeout_no_valid", sv_cnt, 0);
        clear_flags();
        chk("timeout_cleared", tmo_e, 0);

        new_test();
        pulse_tick();
        send(16'h0401); send(16'h0402); send(16'h0403); send(16'h0404);
        wait_pulses(2, 40, "reset_mid_two_pulses");
        reset_pulse(1'b0);
        new_test();
        pulse_tick();
        send(16'h0411); send(16'h0412); send(16'h0413); send(16'h0414);
        wait_pulses(4, 40, "restart_stream_done");
        complete(3'd6);
        cyc_n(2);
        chk_seen("restart_eeg", 16'h0411, 16'h0412, 16'h0413, 16'h0414);
        chk("restart_stage", stage, 6);

        reset_pulse(1'b1);
        new_test();
        pulse_tick();
        send(16'h00a1); send(16'h00a2); send(16'h00a3); send(16'h00a4); send(16'h00a5);
        adc = 16'h00a6; valid = 1; clr = 1; @(negedge clk); valid = 0; clr = 0;
        wait_pulses(4, 60, "overflow_stream_done");
        chk("overflow_flag", ovf, 1);
        complete(3'd4);
        cyc_n(2);
        chk_seen("overflow_eeg", 16'h00a1, 16'h00a2, 16'h00a3, 16'h00a4);
        chk("overflow_stage", stage, 4);

        new_test();
        pulse_tick();
        send(16'h00b1); send(16'h00b2); send(16'h00b3); send(16'h00b4);
        wait_pulses(4, 60, "flush_stream_done");
        complete(3'd0);
        cyc_n(2);
        chk_seen("flush_eeg", 16'h00b1, 16'h00b2, 16'h00b3, 16'h00b4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
